// File: rtl/tl_a_repeater.sv
// One-entry TileLink-UL A-channel repeater: captures a beat fired with repeat_beat high
// and re-presents it, stalling the producer, until a fire with repeat_beat low releases it.
module tl_a_repeater #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned SOURCE_W = 5,
  parameter int unsigned SIZE_W   = 3,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CNT_W    = 4,
  localparam int unsigned MASK_W  = DATA_W / 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                repeat_beat,
  output logic                full,
  input  logic                enq_valid,
  output logic                enq_ready,
  input  logic [2:0]          enq_opcode,
  input  logic [2:0]          enq_param,
  input  logic [SIZE_W-1:0]   enq_size,
  input  logic [SOURCE_W-1:0] enq_source,
  input  logic [ADDR_W-1:0]   enq_address,
  input  logic [MASK_W-1:0]   enq_mask,
  input  logic [DATA_W-1:0]   enq_data,
  output logic                deq_valid,
  input  logic                deq_ready,
  output logic [2:0]          deq_opcode,
  output logic [2:0]          deq_param,
  output logic [SIZE_W-1:0]   deq_size,
  output logic [SOURCE_W-1:0] deq_source,
  output logic [ADDR_W-1:0]   deq_address,
  output logic [MASK_W-1:0]   deq_mask,
  output logic [DATA_W-1:0]   deq_data,
  output logic [MASK_W-1:0]   saved_mask,
  output logic [CNT_W-1:0]    repeat_cnt,
  output logic                err_repeat
);

  typedef enum logic {EMPTY, HOLD} state_e;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;

  state_e              state_q, state_d;
  logic [2:0]          opcode_q, opcode_d;
  logic [2:0]          param_q, param_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [SOURCE_W-1:0] source_q, source_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                deq_fire;

  always_comb begin
    full       = (state_q == HOLD);
    deq_valid  = enq_valid | full;
    enq_ready  = deq_ready & ~full;
    deq_fire   = deq_valid & deq_ready;

    deq_opcode  = full ? opcode_q  : enq_opcode;
    deq_param   = full ? param_q   : enq_param;
    deq_size    = full ? size_q    : enq_size;
    deq_source  = full ? source_q  : enq_source;
    deq_address = full ? address_q : enq_address;
    deq_mask    = full ? mask_q    : enq_mask;
    deq_data    = full ? data_q    : enq_data;

    // Saved registers keep their last value after release; gate the exported mask instead.
    saved_mask = full ? mask_q : '0;
    repeat_cnt = cnt_q;
    err_repeat = err_q;
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    param_d   = param_q;
    size_d    = size_q;
    source_d  = source_q;
    address_d = address_q;
    mask_d    = mask_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    err_d     = err_q;

    case (state_q)
      EMPTY: begin
        if (deq_fire && repeat_beat) begin
          state_d   = HOLD;
          opcode_d  = enq_opcode;
          param_d   = enq_param;
          size_d    = enq_size;
          source_d  = enq_source;
          address_d = enq_address;
          mask_d    = enq_mask;
          data_d    = enq_data;
          cnt_d     = CNT_W'(1);
        end
      end
      HOLD: begin
        if (deq_fire) begin
          if (repeat_beat) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            if (opcode_q == OP_PUT_FULL && mask_q != '1) begin
              err_d = 1'b1;
            end
          end else begin
            state_d = EMPTY;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= EMPTY;
      opcode_q  <= '0;
      param_q   <= '0;
      size_q    <= '0;
      source_q  <= '0;
      address_q <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      param_q   <= param_d;
      size_q    <= size_d;
      source_q  <= source_d;
      address_q <= address_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_tl_a_repeater.sv
// Directed self-checking bench for tl_a_repeater: pass-through, repeat, stall,
// counter saturation, PutFull mask error and asynchronous reset while holding.
module tb_tl_a_repeater;

  logic        clock;
  logic        reset_n;
  logic        repeat_beat;
  logic        full;
  logic        enq_valid;
  logic        enq_ready;
  logic [2:0]  enq_opcode;
  logic [2:0]  enq_param;
  logic [2:0]  enq_size;
  logic [4:0]  enq_source;
  logic [11:0] enq_address;
  logic [3:0]  enq_mask;
  logic [31:0] enq_data;
  logic        deq_valid;
  logic        deq_ready;
  logic [2:0]  deq_opcode;
  logic [2:0]  deq_param;
  logic [2:0]  deq_size;
  logic [4:0]  deq_source;
  logic [11:0] deq_address;
  logic [3:0]  deq_mask;
  logic [31:0] deq_data;
  logic [3:0]  saved_mask;
  logic [3:0]  repeat_cnt;
  logic        err_repeat;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  tl_a_repeater #(
    .ADDR_W(12), .SOURCE_W(5), .SIZE_W(3), .DATA_W(32), .CNT_W(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .repeat_beat(repeat_beat), .full(full),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_opcode(enq_opcode),
    .enq_param(enq_param), .enq_size(enq_size), .enq_source(enq_source),
    .enq_address(enq_address), .enq_mask(enq_mask), .enq_data(enq_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_opcode(deq_opcode),
    .deq_param(deq_param), .deq_size(deq_size), .deq_source(deq_source),
    .deq_address(deq_address), .deq_mask(deq_mask), .deq_data(deq_data),
    .saved_mask(saved_mask), .repeat_cnt(repeat_cnt), .err_repeat(err_repeat)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; registered effects are seen one falling edge later.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset_n     = 1'b0;
    repeat_beat = 1'b0;
    enq_valid   = 1'b0;
    deq_ready   = 1'b1;
    enq_opcode  = 3'd4;
    enq_param   = 3'd0;
    enq_size    = 3'd2;
    enq_source  = 5'd3;
    enq_address = 12'h000;
    enq_mask    = 4'hf;
    enq_data    = 32'h0;
    #2;
    check("rst_full", full, 0);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_enq_ready", enq_ready, 1);
    check("rst_cnt", repeat_cnt, 0);
    check("rst_err", err_repeat, 0);
    check("rst_saved_mask", saved_mask, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Pass-through
    enq_valid   = 1'b1;
    enq_address = 12'h040;
    enq_data    = 32'hdead_beef;
    #1;
    check("pt_deq_valid", deq_valid, 1);
    check("pt_deq_addr", deq_address, 12'h040);
    check("pt_deq_data", deq_data, 32'hdead_beef);
    check("pt_enq_ready", enq_ready, 1);
    tick();
    check("pt_full_after", full, 0);

    // Repeat x3 of a Get at 0x100
    enq_address = 12'h100;
    enq_source  = 5'd7;
    repeat_beat = 1'b1;
    #1;
    check("r3_fire1_addr", deq_address, 12'h100);
    check("r3_fire1_enq_ready", enq_ready, 1);
    tick();
    check("r3_full1", full, 1);
    check("r3_cnt1", repeat_cnt, 1);
    check("r3_enq_ready1", enq_ready, 0);
    enq_address = 12'h200;
    enq_source  = 5'd9;
    #1;
    check("r3_fire2_addr", deq_address, 12'h100);
    check("r3_fire2_src", deq_source, 7);
    tick();
    check("r3_cnt2", repeat_cnt, 2);
    check("r3_enq_ready2", enq_ready, 0);
    repeat_beat = 1'b0;
    #1;
    check("r3_fire3_addr", deq_address, 12'h100);
    tick();
    check("r3_full_rel", full, 0);
    check("r3_cnt_rel", repeat_cnt, 0);
    check("r3_enq_ready_rel", enq_ready, 1);
    check("r3_pt_addr", deq_address, 12'h200);

    // Stall in HOLD
    enq_address = 12'h300;
    repeat_beat = 1'b1;
    tick();
    check("st_full", full, 1);
    deq_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enq_address = 12'h3a0 + 12'(i);
      tick();
      check("st_addr", deq_address, 12'h300);
      check("st_cnt", repeat_cnt, 1);
      check("st_deq_valid", deq_valid, 1);
      check("st_enq_ready", enq_ready, 0);
    end
    deq_ready   = 1'b1;
    repeat_beat = 1'b0;
    tick();
    check("st_full_rel", full, 0);
    check("st_cnt_rel", repeat_cnt, 0);

    // Saturation over 20 repeated fires
    enq_address = 12'h500;
    repeat_beat = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("sat_cnt", repeat_cnt, (k < 15) ? k : 15);
    end
    check("sat_err_get", err_repeat, 0);
    repeat_beat = 1'b0;
    tick();
    check("sat_cnt_rel", repeat_cnt, 0);
    check("sat_full_rel", full, 0);

    // PutFull with partial mask, repeated
    enq_opcode  = 3'd0;
    enq_mask    = 4'h3;
    enq_address = 12'h600;
    repeat_beat = 1'b1;
    tick();
    check("me_full", full, 1);
    check("me_saved_mask", saved_mask, 4'h3);
    check("me_err_first", err_repeat, 0);
    tick();
    check("me_err_second", err_repeat, 1);
    repeat_beat = 1'b0;
    tick();
    check("me_saved_mask_rel", saved_mask, 0);
    check("me_err_sticky1", err_repeat, 1);
    enq_opcode = 3'd4;
    enq_mask   = 4'hf;
    tick();
    check("me_err_sticky2", err_repeat, 1);

    // Asynchronous reset while holding
    enq_address = 12'h700;
    repeat_beat = 1'b1;
    tick();
    check("ar_full_before", full, 1);
    enq_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_full", full, 0);
    check("ar_deq_valid_lo", deq_valid, 0);
    check("ar_cnt", repeat_cnt, 0);
    check("ar_err", err_repeat, 0);
    check("ar_saved_mask", saved_mask, 0);
    enq_valid = 1'b1;
    #1;
    check("ar_deq_valid_hi", deq_valid, 1);
    check("ar_deq_addr", deq_address, 12'h700);
    @(negedge clock);
    reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
